// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier operand streamers:
// state encoding, default geometry and flat-matrix index helpers.
package matrix_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } state_e;

   localparam int unsigned DEFAULT_N = 2;
   localparam int unsigned DEFAULT_W = 3;

   // Element index of B[k][j] in a row-major flat matrix.
   function automatic int unsigned b_index(input int unsigned k,
                                           input int unsigned j,
                                           input int unsigned n);
      return k * n + j;
   endfunction

endpackage

// File: rtl/nested_index_counter.sv
// Three nested wrapping counters (i outer, j middle, k inner), each 0..N-1.
// Exposes the post-advance k/j values so a consumer can register the next selection.
module nested_index_counter
   import matrix_pkg::*;
#(
   parameter int unsigned N = DEFAULT_N
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clear,
   input  logic                                 advance,
   output logic [((N > 2) ? $clog2(N) : 1)-1:0] k_next,
   output logic [((N > 2) ? $clog2(N) : 1)-1:0] j_next,
   output logic                                 last
);

   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] MAX = CW'(N - 1);

   logic [CW-1:0] i_q, i_d;
   logic [CW-1:0] j_q, j_d;
   logic [CW-1:0] k_q, k_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q <= '0;
         j_q <= '0;
         k_q <= '0;
      end else begin
         i_q <= i_d;
         j_q <= j_d;
         k_q <= k_d;
      end
   end

   always_comb begin
      i_d = i_q;
      j_d = j_q;
      k_d = k_q;
      if (clear) begin
         i_d = '0;
         j_d = '0;
         k_d = '0;
      end else if (advance) begin
         k_d = (k_q == MAX) ? '0 : k_q + 1'b1;
         if (k_q == MAX) begin
            j_d = (j_q == MAX) ? '0 : j_q + 1'b1;
            if (j_q == MAX) begin
               i_d = (i_q == MAX) ? '0 : i_q + 1'b1;
            end
         end
      end
   end

   assign k_next = k_d;
   assign j_next = j_d;
   assign last   = (i_q == MAX) && (j_q == MAX) && (k_q == MAX);

endmodule

// File: rtl/matrix_b_streamer.sv
// Matrix B operand sequencer: snapshots B on start and streams B[k][j] for
// k innermost, j middle, repeated N times, over a registered valid/ready port.
module matrix_b_streamer
   import matrix_pkg::*;
#(
   parameter int unsigned N = DEFAULT_N,
   parameter int unsigned W = DEFAULT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N*N*W-1:0] matrix_b,
   output logic [W-1:0]     element,
   output logic             valid,
   input  logic             ready,
   output logic             k_last,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] MAX = CW'(N - 1);

   state_e             state_q, state_d;
   logic [N*N*W-1:0]   snap_q, snap_d;
   logic [W-1:0]       element_q, element_d;
   logic               valid_q, valid_d;
   logic               k_last_q, k_last_d;

   logic               accept;
   logic               xfer;
   logic               cnt_last;
   logic [CW-1:0]      k_nx;
   logic [CW-1:0]      j_nx;

   assign accept = (state_q == IDLE) && start;
   assign xfer   = valid_q && ready;

   nested_index_counter #(
      .N(N)
   ) u_idx (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept),
      .advance(xfer),
      .k_next (k_nx),
      .j_next (j_nx),
      .last   (cnt_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         element_q <= '0;
         valid_q   <= 1'b0;
         k_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         element_q <= element_d;
         valid_q   <= valid_d;
         k_last_q  <= k_last_d;
      end
   end

   // Output registers are loaded with the beat that follows each transfer,
   // so the presented beat holds untouched while the consumer stalls.
   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      element_d = element_q;
      valid_d   = valid_q;
      k_last_d  = k_last_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = STREAM;
               snap_d    = matrix_b;
               element_d = matrix_b[W-1:0];
               valid_d   = 1'b1;
               k_last_d  = 1'b0;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (cnt_last) begin
                  state_d   = DONE;
                  element_d = '0;
                  valid_d   = 1'b0;
                  k_last_d  = 1'b0;
               end else begin
                  element_d = snap_q[b_index(32'(k_nx), 32'(j_nx), N) * W +: W];
                  k_last_d  = (k_nx == MAX);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      element = element_q;
      valid   = valid_q;
      k_last  = k_last_q;
      busy    = (state_q == STREAM) || (state_q == DONE);
      done    = (state_q == DONE);
   end

endmodule

// File: doc/matrix_b_streamer.md
# matrix_b_streamer

Parametrised operand sequencer for matrix B in the matrix multiplier datapath. Snapshots an N×N matrix of W-bit elements on `start` and streams its elements over a valid/ready handshake in the exact order the multiply-accumulate stage consumes them. For each result entry C[i][j], it emits B[0][j], B[1][j], …, B[N-1][j], and it repeats the full column sweep once per row of A. It replaces the fixed 2×2, 3-bit, externally indexed selector with an internally sequenced, back-pressurable source.

## Interface
- `N`, default 2: matrix dimension, ≥2.
- `W`, default 3: element width in bits, ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a multiply; sampled only in IDLE.
- `matrix_b`  in  N*N*W  flat row-major B; element B[r][c] occupies bits [(r*N+c)*W +: W].
- `element`  out  W  current B element.
- `valid`  out  1  `element` is valid.
- `ready`  in  1  consumer accepts `element` this cycle.
- `k_last`  out  1  current element is the final term (k=N-1) of a dot product.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is exited.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States:
  - IDLE → STREAM on `start`.
  - STREAM → DONE on acceptance of the final beat.
  - DONE → IDLE unconditionally after 1 cycle.
- On `start` in IDLE: latch `matrix_b` into an internal snapshot and clear counters i, j, k to 0. `matrix_b` changes after this point have no effect until the next accepted `start`.
- `start` is ignored in STREAM and DONE. No queueing.
- Three nested counters, each 0..N-1, width $clog2(N), minimum 1 bit:
  - k is innermost.
  - j is the middle counter.
  - i is outermost; it counts rows of A and is not used for selection.
- Emitted element = snapshot[(k*N + j)*W +: W].
- A beat is transferred when `valid && ready`. On a transfer:
  - k increments.
  - On k wrap, j increments.
  - On j wrap, i increments.
- Final beat: i = j = k = N-1. Total beats per operation = N³.
- `k_last` = (k == N-1) while `valid`, else 0.
- Handshake rules:
  - `element`, `k_last`, and `valid` are registered.
  - While `valid && !ready`, all three hold stable.
  - `valid` never drops without a transfer, except on reset.
- `busy` is high in STREAM and DONE.
- `done` is high only in DONE.
- Reset (async, any state, including mid-stream):
  - state = IDLE; i = j = k = 0; snapshot = 0.
  - `element` = 0, `valid` = 0, `k_last` = 0, `busy` = 0, `done` = 0.
  - No partial beat is emitted after reset deasserts.

## Timing
- `start` sampled high in IDLE at edge t → `valid` = 1 with B[0][0] and `busy` = 1 after edge t.
- With `ready` held at 1: one beat per cycle. The final beat is presented at t+N³−1 (after edge t+N³−1).
- Edge after the final transfer: `valid` = 0 and `done` = 1.
- Next edge: `done` = 0, `busy` = 0, state = IDLE. The earliest new `start` is sampled on the following edge.
- The next beat is visible the cycle after each transfer. `ready` has no combinational path to any output.

## Structure
- Shared `matrix_pkg`:
  - state enum (IDLE, STREAM, DONE);
  - default N and W constants;
  - index function `b_index(k, j, N)` = k*N + j, reused by the matrix A streamer (row-major `i*N + k`).
- One natural sub-module: `nested_index_counter`, parameter N. It holds the three wrapping counters with an `advance` input and a `last` output, and is shared with the A streamer.
- Selection is an indexed part-select on the snapshot register. There is no case statement, so any N works.

## Test plan
- N=2, W=3, B00=1, B01=2, B10=3, B11=4 (`matrix_b` = 12'b100_011_010_001), `start` pulse, `ready`=1:
  - `element` stream 1,3,2,4,1,3,2,4.
  - `k_last` high on beats 2,4,6,8.
  - `done` pulse one cycle after beat 8; `busy` low the cycle after that.
- Same setup, `ready` low for 3 cycles while beat 3 (value 2) is presented: value 2, `valid`=1, and `k_last`=0 hold for all 3 cycles; the stream then resumes with 4.
- Change `matrix_b` to all 7s and pulse `start` again during beat 4: the stream is unchanged and no restart occurs. A `start` asserted during DONE is also ignored.
- Assert `rst` during beat 5: all outputs read 0 in the same cycle. A fresh `start` afterwards restarts from B00.
- N=3, W=8, B[r][c] = 10r + c:
  - 27 beats; first 9 are 0,10,20,1,11,21,2,12,22, then the pattern repeats twice.
  - `k_last` high on every 3rd beat.
- Random `ready` (50%) with N=4, W=5: the scoreboard matches the N³ = 64 expected beats in order, with no loss or duplication.
